// File: rtl/loopback_gmii_tx_framer_pkg.sv
// Shared definitions for the GMII transmit framer: upstream word layout,
// preamble/SFD constants and FSM state encoding.
package loopback_gmii_tx_framer_pkg;

  localparam int SOP_BIT  = 0;
  localparam int EOP_BIT  = 1;
  localparam int ERR_BIT  = 2;
  localparam int BYTE_LSB = 3;
  localparam int BYTE_MSB = 10;
  localparam int WORD_W   = 11;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_DATA     = 3'd3,
    ST_IPG      = 3'd4
  } state_t;

endpackage

// File: rtl/loopback_gmii_tx_framer.sv
// GMII transmit framer: wraps upstream bytes with preamble/SFD, flags
// underruns and stray sop words, and enforces the inter-packet gap.
module loopback_gmii_tx_framer
  import loopback_gmii_tx_framer_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int IPG_CYCLES   = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [10:0] in_data,
  output logic        in_ready,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic [15:0] frame_count,
  output logic [7:0]  underrun_count,
  output logic [2:0]  dbg_state
);

  // Handshake: a word transfers on a rising edge where in_valid and in_ready
  // are both high; in_valid may rise or fall freely, in_ready depends only on
  // state and the sop bit, and is low throughout reset.

  localparam int CNT_MAX = (PREAMBLE_LEN > IPG_CYCLES) ? PREAMBLE_LEN : IPG_CYCLES;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [7:0]         txd_q;
  logic               tx_en_q;
  logic               tx_er_q;
  logic [15:0]        frame_cnt_q;
  logic [7:0]         urun_cnt_q;
  logic               urun_seen_q;

  logic               w_sop;
  logic               w_eop;
  logic               w_err;
  logic [7:0]         w_byte;

  assign w_sop  = in_data[SOP_BIT];
  assign w_eop  = in_data[EOP_BIT];
  assign w_err  = in_data[ERR_BIT];
  assign w_byte = in_data[BYTE_MSB:BYTE_LSB];

  always_comb begin
    in_ready = 1'b0;
    if (reset) begin
      case (state_q)
        ST_IDLE:         in_ready = !w_sop;
        ST_SFD, ST_DATA: in_ready = 1'b1;
        default:         in_ready = 1'b0;
      endcase
    end
  end

  // Line outputs are registered together with the state so each line cycle
  // shows the byte belonging to the state it was entered with.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      txd_q       <= 8'h00;
      tx_en_q     <= 1'b0;
      tx_er_q     <= 1'b0;
      frame_cnt_q <= 16'h0000;
      urun_cnt_q  <= 8'h00;
      urun_seen_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          txd_q   <= 8'h00;
          tx_en_q <= 1'b0;
          tx_er_q <= 1'b0;
          if (in_valid && w_sop) begin
            state_q     <= ST_PREAMBLE;
            cnt_q       <= CNT_W'(PREAMBLE_LEN - 1);
            txd_q       <= PREAMBLE_BYTE;
            tx_en_q     <= 1'b1;
            urun_seen_q <= 1'b0;
          end
        end

        ST_PREAMBLE: begin
          tx_en_q <= 1'b1;
          tx_er_q <= 1'b0;
          if (cnt_q == '0) begin
            state_q <= ST_SFD;
            txd_q   <= SFD_BYTE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            txd_q <= PREAMBLE_BYTE;
          end
        end

        ST_SFD, ST_DATA: begin
          tx_en_q <= 1'b1;
          if (in_valid) begin
            txd_q   <= w_byte;
            // A sop inside a running frame is a framing error on that byte.
            tx_er_q <= w_err || (w_sop && (state_q == ST_DATA));
            if (w_eop) begin
              state_q     <= ST_IPG;
              cnt_q       <= CNT_W'(IPG_CYCLES);
              frame_cnt_q <= frame_cnt_q + 16'd1;
            end else begin
              state_q <= ST_DATA;
            end
          end else begin
            txd_q   <= 8'h00;
            tx_er_q <= 1'b1;
            state_q <= ST_DATA;
            if (!urun_seen_q) begin
              urun_seen_q <= 1'b1;
              if (urun_cnt_q != 8'hFF) begin
                urun_cnt_q <= urun_cnt_q + 8'd1;
              end
            end
          end
        end

        ST_IPG: begin
          // The first IPG cycle carries the eop byte, so loading IPG_CYCLES
          // yields exactly IPG_CYCLES quiet line cycles before IDLE.
          txd_q   <= 8'h00;
          tx_en_q <= 1'b0;
          tx_er_q <= 1'b0;
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          txd_q   <= 8'h00;
          tx_en_q <= 1'b0;
          tx_er_q <= 1'b0;
        end
      endcase
    end
  end

  assign gmii_txd       = txd_q;
  assign gmii_tx_en     = tx_en_q;
  assign gmii_tx_er     = tx_er_q;
  assign frame_count    = frame_cnt_q;
  assign underrun_count = urun_cnt_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_loopback_gmii_tx_framer.sv
// Self-checking bench for the GMII transmit framer: IDLE vector table,
// directed frame scenarios and randomized frames against a frame-level model.
module tb_loopback_gmii_tx_framer;
  import loopback_gmii_tx_framer_pkg::*;

  localparam int PRE = 7;
  localparam int IPG = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [10:0] in_data;
  logic        in_ready;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en;
  logic        gmii_tx_er;
  logic [15:0] frame_count;
  logic [7:0]  underrun_count;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  loopback_gmii_tx_framer #(.PREAMBLE_LEN(PRE), .IPG_CYCLES(IPG)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en),
    .gmii_tx_er(gmii_tx_er), .frame_count(frame_count),
    .underrun_count(underrun_count), .dbg_state(dbg_state)
  );

  typedef struct {
    logic        gap;
    logic [10:0] data;
  } item_t;

  typedef struct {
    logic        v;
    logic [10:0] d;
    logic        rdy;
  } vec_t;

  item_t      drv_q[$];
  logic [8:0] exp_q[$];
  vec_t       vt[6];

  int          n_checks;
  int          n_fail;
  logic        drv_manual;
  logic        seen_hi;
  int          low_run;
  int          last_low_run;
  logic [15:0] exp_frames;
  logic [7:0]  exp_under;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic driver_loop();
    logic  acc;
    item_t it;
    forever begin
      if (drv_manual) begin
        @(posedge clk); #1;
      end else if (drv_q.size() == 0) begin
        in_valid = 1'b0; in_data = '0;
        @(posedge clk); #1;
      end else if (drv_q[0].gap) begin
        in_valid = 1'b0; in_data = '0;
        @(posedge clk);
        if (drv_q.size() > 0) it = drv_q.pop_front();
        #1;
      end else begin
        in_valid = 1'b1; in_data = drv_q[0].data;
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        if (acc && reset && drv_q.size() > 0) it = drv_q.pop_front();
        #1;
      end
    end
  endtask

  task automatic monitor_loop();
    logic [8:0] e9;
    forever begin
      @(negedge clk);
      if (!reset) begin
        seen_hi = 1'b0; low_run = 0;
      end else if (gmii_tx_en) begin
        if (seen_hi && low_run > 0) begin
          check("ipg_min_gap", 32'(low_run >= IPG + 1), 32'd1);
          last_low_run = low_run;
        end
        seen_hi = 1'b1; low_run = 0;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_byte: got txd=0x%0h er=%0b, required no transmission", gmii_txd, gmii_tx_er);
        end else begin
          e9 = exp_q.pop_front();
          check("tx_byte", {gmii_tx_er, gmii_txd}, e9);
        end
      end else begin
        low_run++;
        check("idle_lines", {gmii_tx_er, gmii_txd}, 9'h000);
      end
    end
  endtask

  // Frame-level model: preamble, SFD, then payload in order with error flags
  // and one 0x00/er byte per upstream gap cycle.
  task automatic add_frame(input int len, input logic [7:0] base, input int gap_after,
                           input int gap_len, input int err_idx, input int sop_idx);
    item_t it;
    logic [7:0] b;
    logic e, s;
    for (int k = 0; k < PRE; k++) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
    for (int i = 0; i < len; i++) begin
      b = base + 8'(i);
      e = (i == err_idx);
      s = (i == 0) || (i == sop_idx);
      it.gap = 1'b0; it.data = {b, e, (i == len - 1), s};
      drv_q.push_back(it);
      exp_q.push_back({e || (i == sop_idx && i != 0), b});
      if (i == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          it.gap = 1'b1; it.data = '0;
          drv_q.push_back(it);
          exp_q.push_back({1'b1, 8'h00});
        end
      end
    end
    exp_frames++;
    if (gap_len > 0 && gap_after >= 0 && gap_after < len - 1 && exp_under != 8'hFF) exp_under++;
  endtask

  task automatic add_stray(input logic [7:0] b, input logic err, input logic eop);
    item_t it;
    it.gap = 1'b0; it.data = {b, err, eop, 1'b0};
    drv_q.push_back(it);
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    while ((drv_q.size() > 0 || exp_q.size() > 0) && t < budget) begin
      @(negedge clk); t++;
    end
    n_checks++;
    if (t >= budget) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d words and %0d bytes pending after %0d cycles, required 0",
               drv_q.size(), exp_q.size(), t);
    end
    repeat (IPG + 3) @(negedge clk);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_frame_count"}, frame_count, exp_frames);
    check({tag, "_underrun_count"}, underrun_count, exp_under);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, ga, gl, ei, si, t;
    n_checks = 0; n_fail = 0; drv_manual = 1'b1;
    seen_hi = 1'b0; low_run = 0; last_low_run = 0;
    exp_frames = 16'h0; exp_under = 8'h0;
    reset = 1'b0; in_valid = 1'b1; in_data = {8'hAA, 3'b000};

    fork
      driver_loop();
      monitor_loop();
    join_none

    // Reset state, with a non-sop word offered
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_tx_en", gmii_tx_en, 1'b0);
    check("rst_txd_er", {gmii_tx_er, gmii_txd}, 9'h000);
    check("rst_counters", {frame_count, underrun_count}, 24'h0);
    check("rst_state", dbg_state, ST_IDLE);
    in_valid = 1'b0; in_data = '0;
    @(negedge clk); reset = 1'b1;

    // IDLE behaviour table: ready follows !sop, nothing is transmitted
    vt[0] = '{1'b0, 11'h000, 1'b1};
    vt[1] = '{1'b0, 11'h001, 1'b0};
    vt[2] = '{1'b1, {8'hAA, 3'b000}, 1'b1};
    vt[3] = '{1'b1, {8'h5A, 3'b110}, 1'b1};
    vt[4] = '{1'b0, {8'hFF, 3'b111}, 1'b0};
    vt[5] = '{1'b1, {8'h33, 3'b010}, 1'b1};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      in_valid = vt[i].v; in_data = vt[i].d;
      #2;
      check("idle_in_ready", in_ready, vt[i].rdy);
      @(posedge clk); #1;
      check("idle_stays_quiet", {gmii_tx_en, dbg_state}, {1'b0, ST_IDLE});
    end
    in_valid = 1'b0; in_data = '0;
    check_counters("idle_table");
    drv_manual = 1'b0;

    // 64-byte frame, continuous valid
    add_frame(64, 8'h01, -1, 0, -1, -1);
    drain(400);
    check_counters("frame64");

    // Two frames back to back: gap is IPG plus one IDLE
    add_frame(20, 8'h80, -1, 0, -1, -1);
    add_frame(20, 8'hA0, -1, 0, -1, -1);
    drain(400);
    check("b2b_gap_len", last_low_run, IPG + 1);
    check_counters("b2b");

    // Three-cycle underrun after byte 10
    add_frame(30, 8'h01, 9, 3, -1, -1);
    drain(400);
    check_counters("underrun");

    // Stray non-sop words in IDLE are discarded
    add_stray(8'h11, 1'b0, 1'b0);
    add_stray(8'h22, 1'b1, 1'b0);
    add_stray(8'h33, 1'b0, 1'b1);
    add_frame(16, 8'hC0, -1, 0, -1, -1);
    drain(400);
    check_counters("strays");

    // Error flag on payload byte 5; stray sop inside a frame; one-word frame
    add_frame(12, 8'h01, -1, 0, 4, -1);
    add_frame(10, 8'h30, -1, 0, -1, 5);
    add_frame(1, 8'h77, -1, 0, -1, -1);
    add_frame(3, 8'h40, 0, 2, 2, -1);
    drain(600);
    check_counters("err_sop_short");

    // Randomized frames with strays, gaps, errors and stray sops
    for (int f = 0; f < 25; f++) begin
      len = $urandom_range(1, 40);
      ga = -1; gl = 0; ei = -1; si = -1;
      if (len > 1 && $urandom_range(0, 2) == 0) begin
        ga = $urandom_range(0, len - 2); gl = $urandom_range(1, 3);
      end
      if ($urandom_range(0, 3) == 0) ei = $urandom_range(0, len - 1);
      if (len > 1 && $urandom_range(0, 4) == 0) si = $urandom_range(1, len - 1);
      t = $urandom_range(0, 2);
      for (int k = 0; k < t; k++)
        add_stray(8'($urandom), 1'($urandom), 1'($urandom));
      add_frame(len, 8'($urandom), ga, gl, ei, si);
    end
    drain(4000);
    check_counters("random");

    // Underrun counter saturates at 0xFF
    for (int f = 0; f < 258; f++) add_frame(2, 8'hE0, 0, 1, -1, -1);
    drain(12000);
    check_counters("saturate");
    check("saturate_value", underrun_count, 8'hFF);

    // Reset while payload byte 20 is on the line
    add_frame(40, 8'h01, -1, 0, -1, -1);
    t = 0;
    do begin
      @(negedge clk); t++;
    end while (!(gmii_tx_en && gmii_txd == 8'h14) && t < 200);
    check("reset_wait_byte20", 32'(t < 200), 32'd1);
    #1;
    reset = 1'b0;
    drv_q.delete(); exp_q.delete();
    exp_frames = 16'h0; exp_under = 8'h0;
    #1;
    check("midrst_tx_en", gmii_tx_en, 1'b0);
    check("midrst_txd_er", {gmii_tx_er, gmii_txd}, 9'h000);
    check("midrst_counters", {frame_count, underrun_count}, 24'h0);
    check("midrst_in_ready", in_ready, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    add_frame(24, 8'h50, -1, 0, -1, -1);
    drain(400);
    check_counters("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
